pc_fetch_gen: RTL and testbench
===============================

Name: pc_fetch_gen

Overview:
Parametrised program-counter and fetch-request generator for the RISC-V core. It replaces the free-running PC with a unit that:
- supports a configurable reset vector and address width;
- issues fetch requests through a valid/ready handshake;
- tracks up to MAX_OUTSTANDING in-flight fetches;
- buffers returned instructions for decode;
- flushes the pipeline on a branch/jump redirect.

It sits between the memory/icache controller and the decode stage.

Parameters:
ADDR_WIDTH, 32, width of PC and fetch addresses
RESET_VECTOR, 32'h0, PC value loaded on reset
INC, 4, bytes added per sequential fetch (power of two)
MAX_OUTSTANDING, 2, in-flight fetches plus buffered instructions (power of two, >=1)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; low freezes all state
stall_in  input  1  decode cannot accept inst this cycle
redirect_valid_in  input  1  branch/jump taken
redirect_addr_in  input  ADDR_WIDTH  redirect target
req_valid_out  output  1  fetch request valid
req_addr_out  output  ADDR_WIDTH  fetch address (= current PC)
req_ready_in  input  1  memory accepts request
resp_valid_in  input  1  fetch data returned (in order)
resp_inst_in  input  32  fetched instruction
inst_valid_out  output  1  inst buffer non-empty
inst_out  output  32  head instruction
inst_pc_out  output  ADDR_WIDTH  PC of head instruction
pc_out  output  ADDR_WIDTH  next fetch address

Behaviour:
- Reset (sync, rst_in=1 at posedge):
  - PC <= RESET_VECTOR.
  - In-flight count and buffer count <= 0; all kill bits cleared.
  - inst_out <= 0, inst_pc_out <= 0.
  - Takes priority over every other input.
  - The memory controller shares rst_in, so no response survives reset.
- rdy_in=0: no state changes; req_valid_out=0; resp_valid_in and redirect_valid_in are ignored.
- Issue rule: req_valid_out = rdy_in & ~redirect_valid_in & (inflight + buf_count < MAX_OUTSTANDING).
  - Handshake = req_valid_out & req_ready_in.
  - On handshake: push {PC, kill=0} into the in-flight queue and set PC <= PC + INC, modulo 2^ADDR_WIDTH (wraps at top).
  - req_addr_out = pc_out = PC register.
- Response handling: on resp_valid_in, pop the in-flight queue head.
  - kill=0: push {resp_inst_in, head PC} into the inst buffer.
  - kill=1: discard.
  - resp_valid_in with inflight=0 is a protocol error and is ignored without a state change.
  - Capacity rule guarantees the buffer never overflows.
- Decode side:
  - inst_valid_out = buf_count != 0.
  - Head pops when inst_valid_out & ~stall_in.
  - Zero-latency bypass from response to output is not allowed: a response becomes visible the cycle after arrival.
- Redirect (redirect_valid_in=1, rdy_in=1):
  - PC <= redirect_addr_in with low log2(INC) bits forced to 0.
  - inst buffer flushed.
  - kill bit set on all in-flight entries.
  - No request is issued that cycle.
  - A response arriving the same cycle is dropped; it is treated as killed.
  - Back-to-back redirects: the last one wins; kill bits stay set.
- Simultaneous events:
  - Response plus decode pop in the same cycle: both occur, buf_count unchanged.
  - Request handshake plus response in the same cycle: both occur.
- Counters are clog2(MAX_OUTSTANDING)+1 bits wide. Queues are circular with wrap-around pointers.

Test Plan:
- Reset RESET_VECTOR=32'h100, rdy_in=1, req_ready_in=1, responses 1 cycle after request, stall_in=0 -> request addresses 0x100,0x104,0x108...; inst_pc_out follows same sequence; no gaps once steady.
- stall_in held high, MAX_OUTSTANDING=2 -> exactly 2 requests (0x0,0x4) issued, req_valid_out stays 0; release stall -> insts 0x0,0x4 delivered in order, fetching resumes at 0x8.
- Two fetches in flight (0x0,0x4), redirect to 0x203 -> pc_out=0x200 next cycle; both old responses dropped; first inst_pc_out = 0x200.
- Redirect and resp_valid_in in the same cycle -> response not delivered; buffer empty next cycle.
- rdy_in low for 5 cycles mid-stream -> pc_out, counts and outputs frozen; req_valid_out=0; sequence continues unchanged afterwards.
- PC=32'hFFFF_FFFC, handshake -> pc_out wraps to 0x0. Assert rst_in mid-stream -> next cycle pc_out=RESET_VECTOR, inst_valid_out=0.

Source files
------------

// File: rtl/pc_fetch_gen.sv
// Program counter and fetch-request generator: issues in-order fetches under a shared
// credit limit, tags in-flight requests with kill bits, and buffers returned instructions for decode.
module pc_fetch_gen #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR    = '0,
  parameter int                    INC             = 4,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  stall_in,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_in,
  output logic                  req_valid_out,
  output logic [ADDR_WIDTH-1:0] req_addr_out,
  input  logic                  req_ready_in,
  input  logic                  resp_valid_in,
  input  logic [31:0]           resp_inst_in,
  output logic                  inst_valid_out,
  output logic [31:0]           inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc_out,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [ADDR_WIDTH-1:0] INC_A      = ADDR_WIDTH'(INC);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INC - 1));
  localparam logic [CNT_W:0]        CAP        = (CNT_W + 1)'(MAX_OUTSTANDING);

  logic [ADDR_WIDTH-1:0]      pc;
  logic [ADDR_WIDTH-1:0]      if_pc [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] if_kill;
  logic [PTR_W-1:0]           if_rd, if_wr;
  logic [CNT_W-1:0]           if_cnt;
  logic [31:0]                buf_inst [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0]      buf_pc [MAX_OUTSTANDING];
  logic [PTR_W-1:0]           buf_rd, buf_wr;
  logic [CNT_W-1:0]           buf_cnt;

  logic [CNT_W:0] occupancy;
  logic           handshake;
  logic           resp_take;
  logic           buf_push;
  logic           dec_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Credits cover both in-flight fetches and buffered instructions, so the buffer cannot overflow.
  always_comb begin
    occupancy     = {1'b0, if_cnt} + {1'b0, buf_cnt};
    req_valid_out = rdy_in & ~redirect_valid_in & (occupancy < CAP);
    handshake     = req_valid_out & req_ready_in;
    resp_take     = rdy_in & resp_valid_in & (if_cnt != '0);
    buf_push      = resp_take & ~if_kill[if_rd] & ~redirect_valid_in;
    dec_pop       = rdy_in & ~redirect_valid_in & (buf_cnt != '0) & ~stall_in;
  end

  assign req_addr_out   = pc;
  assign pc_out         = pc;
  assign inst_valid_out = (buf_cnt != '0);
  assign inst_out       = buf_inst[buf_rd];
  assign inst_pc_out    = buf_pc[buf_rd];

  // PC, in-flight tag queue and instruction buffer; rdy_in low holds everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc      <= RESET_VECTOR;
      if_kill <= '0;
      if_rd   <= '0;
      if_wr   <= '0;
      if_cnt  <= '0;
      buf_rd  <= '0;
      buf_wr  <= '0;
      buf_cnt <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if_pc[i]    <= '0;
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (redirect_valid_in) begin
        pc <= redirect_addr_in & ALIGN_MASK;
      end else if (handshake) begin
        pc <= pc + INC_A;
      end

      if (handshake) begin
        if_pc[if_wr] <= pc;
        if_wr        <= ptr_inc(if_wr);
      end
      if (resp_take) begin
        if_rd <= ptr_inc(if_rd);
      end
      if_cnt <= if_cnt + CNT_W'(handshake) - CNT_W'(resp_take);

      // A request never issues in a redirect cycle, so the two writes cannot collide.
      if (redirect_valid_in) begin
        if_kill <= '1;
      end else if (handshake) begin
        if_kill[if_wr] <= 1'b0;
      end

      if (redirect_valid_in) begin
        buf_rd  <= '0;
        buf_wr  <= '0;
        buf_cnt <= '0;
      end else begin
        if (buf_push) begin
          buf_inst[buf_wr] <= resp_inst_in;
          buf_pc[buf_wr]   <= if_pc[if_rd];
          buf_wr           <= ptr_inc(buf_wr);
        end
        if (dec_pop) begin
          buf_rd <= ptr_inc(buf_rd);
        end
        buf_cnt <= buf_cnt + CNT_W'(buf_push) - CNT_W'(dec_pop);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: queue-based reference model compared every cycle,
// a responder returning data one cycle after each accepted request, and literal spot checks.
module tb_pc_fetch_gen;

  localparam int          AW   = 32;
  localparam logic [31:0] RV   = 32'h0000_0100;
  localparam int          INCB = 4;
  localparam int          MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, stall_in, redirect_valid_in, req_ready_in, resp_valid_in;
  logic [31:0] redirect_addr_in, resp_inst_in;
  logic        req_valid_out, inst_valid_out;
  logic [31:0] req_addr_out, inst_out, inst_pc_out, pc_out;

  always #5 clk = ~clk;

  pc_fetch_gen #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .INC(INCB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
    .redirect_valid_in(redirect_valid_in), .redirect_addr_in(redirect_addr_in),
    .req_valid_out(req_valid_out), .req_addr_out(req_addr_out), .req_ready_in(req_ready_in),
    .resp_valid_in(resp_valid_in), .resp_inst_in(resp_inst_in),
    .inst_valid_out(inst_valid_out), .inst_out(inst_out), .inst_pc_out(inst_pc_out),
    .pc_out(pc_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  // Reference model: plain queues of in-flight fetches and buffered instructions.
  logic [31:0] m_pc;
  logic [31:0] m_if_pc[$];
  bit          m_if_kill[$];
  logic [31:0] m_b_inst[$];
  logic [31:0] m_b_pc[$];
  bit          model_ok = 1'b0;
  logic [31:0] mem_q[$];
  logic [31:0] delivered[$];
  logic [31:0] issued[$];
  bit          auto_resp = 1'b1;
  bit          exp_rv, hs, took, kbit;
  logic [31:0] tpc;

  initial forever begin
    @(negedge clk);
    exp_rv = rdy_in && !redirect_valid_in && ((m_if_pc.size() + m_b_inst.size()) < MAXO);
    if (model_ok) begin
      chk("req_valid", {31'd0, req_valid_out}, {31'd0, exp_rv});
      chk("req_addr", req_addr_out, m_pc);
      chk("pc_out", pc_out, m_pc);
      chk("inst_valid", {31'd0, inst_valid_out}, {31'd0, m_b_inst.size() != 0});
      if (m_b_inst.size() != 0) begin
        chk("inst_out", inst_out, m_b_inst[0]);
        chk("inst_pc", inst_pc_out, m_b_pc[0]);
      end
    end
    if (rst_in) begin
      m_pc = RV;
      m_if_pc.delete(); m_if_kill.delete(); m_b_inst.delete(); m_b_pc.delete();
      mem_q.delete();
      model_ok = 1'b1;
    end else if (model_ok && rdy_in) begin
      hs   = exp_rv && req_ready_in;
      took = 1'b0;
      kbit = 1'b0;
      tpc  = 32'd0;
      if (resp_valid_in && m_if_pc.size() != 0) begin
        took = 1'b1;
        kbit = m_if_kill.pop_front();
        tpc  = m_if_pc.pop_front();
      end
      if (redirect_valid_in) begin
        m_b_inst.delete(); m_b_pc.delete();
        foreach (m_if_kill[i]) m_if_kill[i] = 1'b1;
        m_pc = redirect_addr_in & ~(32'(INCB) - 32'd1);
      end else begin
        if (m_b_inst.size() != 0 && !stall_in) begin
          delivered.push_back(m_b_pc[0]);
          void'(m_b_inst.pop_front());
          void'(m_b_pc.pop_front());
        end
        if (took && !kbit) begin
          m_b_inst.push_back(resp_inst_in);
          m_b_pc.push_back(tpc);
        end
        if (hs) begin
          issued.push_back(m_pc);
          mem_q.push_back(m_pc);
          m_if_pc.push_back(m_pc);
          m_if_kill.push_back(1'b0);
          m_pc = m_pc + 32'(INCB);
        end
      end
    end
  end

  // One clock of stimulus; the responder answers the oldest accepted request.
  task automatic cyc(input bit rst, input bit rdy, input bit stall, input bit redir,
                     input logic [31:0] raddr, input bit ready);
    rst_in            = rst;
    rdy_in            = rdy;
    stall_in          = stall;
    redirect_valid_in = redir;
    redirect_addr_in  = raddr;
    req_ready_in      = ready;
    if (auto_resp && mem_q.size() != 0) begin
      resp_valid_in = 1'b1;
      resp_inst_in  = inst_of(mem_q[0]);
      if (rdy && !rst) void'(mem_q.pop_front());
    end else begin
      resp_valid_in = 1'b0;
      resp_inst_in  = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  logic [31:0] pc_s, ip_s;
  logic        iv_s;
  bit          found;

  initial begin
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("rst_pc", pc_out, 32'h0000_0100);
    chk("rst_inst_valid", {31'd0, inst_valid_out}, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_inst_pc", inst_pc_out, 32'd0);

    // Sequential streaming from the reset vector
    issued.delete(); delivered.delete();
    run(12);
    chk("seq_issue0", issued[0], 32'h0000_0100);
    chk("seq_issue1", issued[1], 32'h0000_0104);
    chk("seq_issue2", issued[2], 32'h0000_0108);
    chk("seq_deliv0", delivered[0], 32'h0000_0100);
    chk("seq_deliv1", delivered[1], 32'h0000_0104);
    chk("seq_deliv2", delivered[2], 32'h0000_0108);

    // Decode stalled: exactly two fetches from 0x0, then resume in order
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    issued.delete(); delivered.delete();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("stall_nissue", 32'(issued.size()), 32'd2);
    chk("stall_issue0", issued[0], 32'h0000_0000);
    chk("stall_issue1", issued[1], 32'h0000_0004);
    chk("stall_req_valid", {31'd0, req_valid_out}, 32'd0);
    chk("stall_ndeliv", 32'(delivered.size()), 32'd0);
    run(6);
    chk("resume_deliv0", delivered[0], 32'h0000_0000);
    chk("resume_deliv1", delivered[1], 32'h0000_0004);
    chk("resume_deliv2", delivered[2], 32'h0000_0008);

    // Two fetches in flight, then redirect to an unaligned target
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    auto_resp = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1);
    issued.delete();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("inflight_issue0", issued[0], 32'h0000_0000);
    chk("inflight_issue1", issued[1], 32'h0000_0004);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0203, 1'b1);
    chk("redir_pc", pc_out, 32'h0000_0200);
    auto_resp = 1'b1;
    delivered.delete();
    run(8);
    chk("redir_first_deliv", delivered[0], 32'h0000_0200);

    // Redirect in the same cycle as a returning response
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_q.size() != 0) found = 1'b1;
      else run(1);
    end
    chk("resp_pending_found", {31'd0, found}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b1);
    chk("redir_resp_dropped", {31'd0, inst_valid_out}, 32'd0);
    run(6);

    // Global enable low freezes everything
    pc_s = pc_out; iv_s = inst_valid_out; ip_s = inst_pc_out;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("frz_pc", pc_out, pc_s);
      chk("frz_req_valid", {31'd0, req_valid_out}, 32'd0);
      chk("frz_inst_valid", {31'd0, inst_valid_out}, {31'd0, iv_s});
      chk("frz_inst_pc", inst_pc_out, ip_s);
    end
    run(6);

    // PC wrap at the top of the address space
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    chk("wrap_start", pc_out, 32'hFFFF_FFFC);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      run(1);
      if (pc_out == 32'h0000_0000) found = 1'b1;
    end
    chk("wrap_pc", pc_out, 32'h0000_0000);
    run(4);

    // Reset in mid-stream
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("mid_rst_pc", pc_out, RV);
    chk("mid_rst_inst_valid", {31'd0, inst_valid_out}, 32'd0);
    run(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
